// File: rtl/entropy_word_collector.sv
// entropy_word_collector: synchronize, sample, von Neumann debias, pack, stream out.
// Define ENTROPY_HEALTH_TEST_EN to add the sticky repetition-count health test.
module entropy_word_collector #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             metastable,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             health_fail
);
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (SAMPLE_DIV < 1) begin : g_bad_div
        $error("SAMPLE_DIV must be >= 1");
    end
    if (REP_LIMIT < 1) begin : g_bad_rep
        $error("REP_LIMIT must be >= 1");
    end

    typedef enum logic {FIRST, SECOND} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          div_q, div_d;
    state_e                 state_q, state_d;
    logic                   first_q, first_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   s, strobe, emit, full, load, hfail;

    assign s    = sync_q[SYNC_STAGES-1];
    assign full = (cnt_q == FULL_CNT);
    assign load = full && (!valid_q || ready) && !hfail;

    // Sample strobe: free-running divider, parked at 0 while disabled.
    always_comb begin
        div_d  = '0;
        strobe = 1'b0;
        if (enable) begin
            if (div_q == DIV_MAX) strobe = 1'b1;
            else div_d = div_q + DW'(1);
        end
    end

    // Debiaser: pair up strobed samples, emit the first bit of an unequal pair.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        emit    = 1'b0;
        if (!enable) begin
            state_d = FIRST;
        end else if (strobe) begin
            case (state_q)
                FIRST: begin
                    first_d = s;
                    state_d = SECOND;
                end
                SECOND: begin
                    emit    = (s != first_q) && !hfail;
                    state_d = FIRST;
                end
            endcase
        end
    end

    // Packing into the shift register and loading the output holding register.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (hfail) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            if (emit) begin
                shreg_d = {{(WIDTH-1){1'b0}}, first_q};
                cnt_d   = CW'(1);
            end else begin
                cnt_d = '0;
            end
        end else if (emit && !full) begin
            shreg_d = {shreg_q[WIDTH-2:0], first_q};
            cnt_d   = cnt_q + CW'(1);
        end
        if (load) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Front end state: synchronizer chain, divider and debiaser FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            div_q   <= '0;
            state_q <= FIRST;
            first_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], metastable};
            div_q   <= div_d;
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Back end state: shift register, bit count and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef ENTROPY_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    logic [RW-1:0] rep_q, rep_d;
    logic          last_q, last_d;
    logic          hf_q, hf_d;

    // Repetition count of identical strobed samples; failure is sticky.
    always_comb begin
        rep_d  = rep_q;
        last_d = last_q;
        hf_d   = hf_q;
        if (strobe) begin
            last_d = s;
            if (s != last_q) rep_d = RW'(1);
            else if (rep_q != REP_MAX) rep_d = rep_q + RW'(1);
            if (rep_d == REP_MAX) hf_d = 1'b1;
        end
    end

    // Health test state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q  <= '0;
            last_q <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            last_q <= last_d;
            hf_q   <= hf_d;
        end
    end

    assign hfail = hf_q;
`else
    assign hfail = 1'b0;
`endif

    assign data_out    = data_q;
    assign valid       = valid_q;
    assign health_fail = hfail;
endmodule

// File: tb/tb_entropy_word_collector.sv
// tb_entropy_word_collector: directed vectors and corner sequences.
// Main instance WIDTH=8 SAMPLE_DIV=1, second instance WIDTH=4 SAMPLE_DIV=3.
module tb_entropy_word_collector;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       metastable = 1'b0;
    logic       enable = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       health_fail;
    logic [3:0] data_out2;
    logic       valid2;
    logic       health_fail2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    entropy_word_collector #(
        .WIDTH(8), .SYNC_STAGES(2), .SAMPLE_DIV(1), .REP_LIMIT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .metastable(metastable),
        .enable(enable), .data_out(data_out), .valid(valid),
        .ready(ready), .health_fail(health_fail)
    );

    entropy_word_collector #(
        .WIDTH(4), .SYNC_STAGES(2), .SAMPLE_DIV(3), .REP_LIMIT(64)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .metastable(metastable),
        .enable(enable), .data_out(data_out2), .valid(valid2),
        .ready(ready), .health_fail(health_fail2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One sample per clock: drive, then step past the next edge.
    task automatic feed(input logic b);
        metastable = b;
        @(posedge clk);
        #1;
    endtask

    // Leaves the design just released, enabled, with samples 0,0 in flight.
    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        ready = 1'b0;
        metastable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    // Feed n bits MSB first, then check valid timing, word and drain.
    task automatic run_word(input logic [31:0] bits, input int n,
                            input logic [7:0] exp, input string name);
        ready = 1'b1;
        for (int i = n - 1; i >= 0; i--) feed(bits[i]);
        feed(1'b0);
        feed(1'b0);
        chk({name, "_early"}, {31'd0, valid}, 32'd0);
        feed(1'b0);
        chk({name, "_valid"}, {31'd0, valid}, 32'd1);
        chk({name, "_data"}, {24'd0, data_out}, {24'd0, exp});
        feed(1'b0);
        chk({name, "_drain"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] pat;

        vecs[0] = '{32'h0000AAAA, 16, 8'hFF};
        vecs[1] = '{32'h00006666, 16, 8'h55};
        vecs[2] = '{32'h00005555, 16, 8'h00};
        vecs[3] = '{32'h000B4A66, 20, 8'hB5};
        vecs[4] = '{32'h00006996, 16, 8'h69};

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_health", {31'd0, health_fail}, 32'd0);

        // Divider: each bit held for three clocks, pairs 10,01,10,10
        do_reset();
        ready = 1'b1;
        pat = 8'h9A;
        for (int k = 7; k >= 0; k--) repeat (3) feed(pat[k]);
        chk("div_early", {31'd0, valid2}, 32'd0);
        feed(1'b0);
        chk("div_valid", {31'd0, valid2}, 32'd1);
        chk("div_data", {28'd0, data_out2}, 32'hB);

        // Table-driven words
        do_reset();
        for (int i = 0; i < 5; i++)
            run_word(vecs[i].bits, vecs[i].n, vecs[i].exp,
                     $sformatf("vec%0d", i));

        // Asynchronous reset mid-word with a held word
        ready = 1'b0;
        for (int i = 15; i >= 0; i--) feed(i[0] == 1'b1);
        repeat (4) feed(1'b0);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        chk("hold_data", {24'd0, data_out}, 32'hFF);
        for (int i = 9; i >= 0; i--) feed(i[0] == 1'b1);
        repeat (2) feed(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, valid}, 32'd0);
        chk("async_data", {24'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        run_word(32'h5555, 16, 8'h00, "post_rst");

        // Backpressure: second word waits in shreg, third group dropped
        do_reset();
        for (int i = 15; i >= 0; i--) feed(i[0] == 1'b1);
        for (int i = 15; i >= 0; i--) feed(i[0] == 1'b0);
        for (int i = 15; i >= 0; i--) feed(i[0] == 1'b1);
        repeat (4) feed(1'b0);
        chk("bp_valid", {31'd0, valid}, 32'd1);
        chk("bp_data", {24'd0, data_out}, 32'hFF);
        ready = 1'b1;
        feed(1'b0);
        ready = 1'b0;
        chk("bp_next_valid", {31'd0, valid}, 32'd1);
        chk("bp_next_data", {24'd0, data_out}, 32'h00);
        feed(1'b0);
        chk("bp_stable", {24'd0, data_out}, 32'h00);
        ready = 1'b1;
        feed(1'b0);
        chk("bp_empty", {31'd0, valid}, 32'd0);
        feed(1'b0);
        run_word(32'hAAAA, 16, 8'hFF, "bp_after");

        // Enable low keeps a partial word of five bits
        do_reset();
        ready = 1'b1;
        pat = 8'd0;
        for (int i = 9; i >= 0; i--) feed(pat[0] ^ ((10'b0110010110 >> i) & 1'b1) ? 1'b1 : 1'b0);
        repeat (2) feed(1'b0);
        enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 98; i++) begin
            feed(i[0] == 1'b0);
            if (valid) seen = 1'b1;
        end
        chk("dis_no_word", {31'd0, seen}, 32'd0);
        repeat (2) feed(1'b0);
        enable = 1'b1;
        run_word(32'h2A, 6, 8'h4F, "reenable");

        // Stuck input: no words; health test only when built in
        do_reset();
        ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            feed(1'b1);
            if (valid) seen = 1'b1;
`ifdef ENTROPY_HEALTH_TEST_EN
            if (i == 64) chk("hf_before", {31'd0, health_fail}, 32'd0);
            if (i == 65) chk("hf_rise", {31'd0, health_fail}, 32'd1);
`endif
        end
        chk("stuck_no_word", {31'd0, seen}, 32'd0);
`ifdef ENTROPY_HEALTH_TEST_EN
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            feed(i[0] == 1'b0);
            if (valid) seen = 1'b1;
        end
        chk("hf_sticky", {31'd0, health_fail}, 32'd1);
        chk("hf_suppress", {31'd0, seen}, 32'd0);
`else
        chk("hf_off", {31'd0, health_fail}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
